// File: rtl/demux8_pkg.sv
// Shared constants, channel-index type and popcount helper for the
// eight-channel demultiplexing holding buffer.
package demux8_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef logic [SEL_W-1:0] ch_idx_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] vec);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + CNT_W'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/demux8_channel.sv
// One-entry holding register: a load fills it, an ack from the consumer
// empties it; a load in the same cycle as an ack wins and keeps it full.
module demux8_channel #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ack,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid_next
);

  // Exposed so the parent can register an occupancy count that tracks
  // valid on the same edge instead of one cycle behind.
  assign valid_next = load | (valid & ~ack);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the data word is reset too, since consumers may observe it
      // directly; it is a single register, not a memory array.
      data  <= '0;
    end else begin
      valid <= valid_next;
      if (load) begin
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/demux8_hold.sv
// Eight-channel demultiplexing holding buffer. Optional round-robin target
// selection is compiled in with DEMUX8_AUTOINC_EN.
module demux8_hold
  import demux8_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]             select,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         enable,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ack,
  output logic [CNT_W-1:0]             full_count
`ifdef DEMUX8_AUTOINC_EN
  ,
  input  logic                         auto_mode
`endif
);

  ch_idx_t             target;
  logic                transfer;
  logic [NUM_CH-1:0]   load;
  logic [NUM_CH-1:0]   valid_next;

`ifdef DEMUX8_AUTOINC_EN
  ch_idx_t ptr;

  assign target = auto_mode ? ptr : ch_idx_t'(select);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (auto_mode && transfer) begin
      ptr <= ptr + ch_idx_t'(1);
    end
  end
`else
  assign target = ch_idx_t'(select);
`endif

  // Gated by rst_n so no handshake completes while the block is held in reset.
  assign in_ready = rst_n & enable & (~out_valid[target] | out_ack[target]);
  assign transfer = in_valid & in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load = '0;
    if (transfer) begin
      load[target] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux8_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .ack       (out_ack[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .valid_next(valid_next[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_count <= '0;
    end else begin
      full_count <= popcount(valid_next);
    end
  end

endmodule

// File: tb/tb_demux8_hold.sv
// Directed-vector bench for demux8_hold with DATA_WIDTH=4; the auto-mode
// section is compiled only when DEMUX8_AUTOINC_EN is defined.
`timescale 1ns/1ps
module tb_demux8_hold;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [2:0]    select;
  logic          in_valid;
  logic          in_ready;
  logic          enable;
  logic [31:0]   out_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ack;
  logic [3:0]    full_count;
`ifdef DEMUX8_AUTOINC_EN
  logic          auto_mode;
`endif

  int vectors = 0;
  int miscompares = 0;

  demux8_hold #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .select    (select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enable    (enable),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .full_count(full_count)
`ifdef DEMUX8_AUTOINC_EN
    ,
    .auto_mode (auto_mode)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ch_data(input logic [31:0] bus, input int k);
    return bus[k*4 +: 4];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    select   = '0;
    in_valid = 1'b0;
    enable   = 1'b1;
    out_ack  = '0;
`ifdef DEMUX8_AUTOINC_EN
    auto_mode = 1'b0;
`endif
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {24'd0, out_valid}, 32'h0);
    check("rst_count", {28'd0, full_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_valid", {24'd0, out_valid}, 32'h0);
    check("idle_count", {28'd0, full_count}, 32'd0);

    // Single transfer to channel 5.
    select = 3'd5; in_data = 4'hA; in_valid = 1'b1;
    #1 check("ch5_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("ch5_valid", {24'd0, out_valid}, 32'h20);
    check("ch5_data", {28'd0, ch_data(out_data, 5)}, 32'hA);
    check("ch5_count", {28'd0, full_count}, 32'd1);

    // Back-pressure on a full channel, then reload with a same-cycle ack.
    select = 3'd2; in_data = 4'h3; in_valid = 1'b1;
    tick();
    in_data = 4'h6;
    #1 check("ch2_full_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("ch2_stall_valid", {24'd0, out_valid}, 32'h24);
    check("ch2_stall_data", {28'd0, ch_data(out_data, 2)}, 32'h3);
    out_ack = 8'h04;
    #1 check("ch2_ack_ready", {31'd0, in_ready}, 32'd1);
    tick();
    out_ack = '0; in_valid = 1'b0;
    check("ch2_reload_valid", {24'd0, out_valid}, 32'h24);
    check("ch2_reload_data", {28'd0, ch_data(out_data, 2)}, 32'h6);
    check("ch2_reload_count", {28'd0, full_count}, 32'd2);

    // Fill every channel with k+1; channels 2 and 5 are reloaded via ack.
    for (int k = 0; k < 8; k++) begin
      select = 3'(k); in_data = 4'(k + 1); in_valid = 1'b1;
      out_ack = (k == 2 || k == 5) ? 8'(1 << k) : 8'h00;
      #1 check($sformatf("fill%0d_ready", k), {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0; out_ack = '0;
    check("fill_valid", {24'd0, out_valid}, 32'hFF);
    check("fill_count", {28'd0, full_count}, 32'd8);
    check("fill_data", out_data, 32'h87654321);

    // Simultaneous acks on channels 0, 3 and 7; data stays put.
    out_ack = 8'h89;
    tick();
    out_ack = '0;
    check("ack3_valid", {24'd0, out_valid}, 32'h76);
    check("ack3_count", {28'd0, full_count}, 32'd5);
    check("ack3_data", out_data, 32'h87654321);

    // Back-to-back words into channel 3 with an ack each cycle.
    select = 3'd3; in_data = 4'hC; in_valid = 1'b1;
    tick();
    in_data = 4'hD; out_ack = 8'h08;
    #1 check("thru_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ack = '0;
    check("thru_data", {28'd0, ch_data(out_data, 3)}, 32'hD);
    check("thru_valid", {24'd0, out_valid}, 32'h7E);
    check("thru_count", {28'd0, full_count}, 32'd6);

    // enable=0 blocks the producer but acks still clear channel 1.
    enable = 1'b0; select = 3'd0; in_data = 4'hF; in_valid = 1'b1; out_ack = 8'h02;
    #1 check("dis_ready", {31'd0, in_ready}, 32'd0);
    tick();
    out_ack = '0; in_valid = 1'b0;
    check("dis_valid", {24'd0, out_valid}, 32'h7C);
    check("dis_count", {28'd0, full_count}, 32'd5);
    check("dis_ch0_data", {28'd0, ch_data(out_data, 0)}, 32'h1);

    // in_ready mirrors target availability with in_valid low.
    enable = 1'b1; select = 3'd1;
    #1 check("avail_empty", {31'd0, in_ready}, 32'd1);
    select = 3'd2;
    #1 check("avail_full", {31'd0, in_ready}, 32'd0);

    // Acks to every channel, including empty ones.
    out_ack = 8'hFF;
    tick();
    out_ack = '0;
    check("ackall_valid", {24'd0, out_valid}, 32'h00);
    check("ackall_count", {28'd0, full_count}, 32'd0);

    // Asynchronous reset mid-transfer.
    select = 3'd4; in_data = 4'h9; in_valid = 1'b1;
    tick();
    in_data = 4'h5;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {24'd0, out_valid}, 32'h00);
    check("arst_data", out_data, 32'h0);
    check("arst_count", {28'd0, full_count}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef DEMUX8_AUTOINC_EN
    // Round robin: values 0..7 land in channels 0..7.
    auto_mode = 1'b1; select = 3'd6;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'(i); in_valid = 1'b1;
      #1 check($sformatf("auto%0d_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("auto_fill_data", out_data, 32'h76543210);
    check("auto_fill_valid", {24'd0, out_valid}, 32'hFF);
    // Values 8 and 9 wrap to channels 0 and 1 and stall until acked.
    for (int i = 8; i < 10; i++) begin
      in_data = 4'(i); in_valid = 1'b1;
      #1 check($sformatf("auto%0d_stall", i), {31'd0, in_ready}, 32'd0);
      tick();
      out_ack = 8'(1 << (i - 8));
      #1 check($sformatf("auto%0d_ack_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      out_ack = '0; in_valid = 1'b0;
      check($sformatf("auto%0d_data", i), {28'd0, ch_data(out_data, i - 8)}, 32'(i));
    end
    check("auto_wrap_valid", {24'd0, out_valid}, 32'hFF);
    // Reset mid-sequence: pointer restarts at channel 0.
    rst_n = 1'b0;
    #1 check("auto_rst_valid", {24'd0, out_valid}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_data = 4'hE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("auto_rst_ptr_valid", {24'd0, out_valid}, 32'h01);
    check("auto_rst_ptr_data", {28'd0, ch_data(out_data, 0)}, 32'hE);
    auto_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
